add_pipe: RTL and testbench
===========================

# add_pipe

Parametrised, pipelined two's-complement adder/subtractor with valid/ready handshakes on both sides. A WIDTH-bit add is split into SEG-bit segments, and one segment is resolved per pipeline stage. This gives one result per cycle at any width without a full-width carry chain in a single cycle. The block is the width-generic, registered successor to the fixed 4-bit ripple adder, and it sits between arithmetic producers and consumers that may stall.

## Interface
- WIDTH, default 32: operand/result width in bits; must be ≥ 1.
- SEG, default 8: bits resolved per stage; WIDTH % SEG == 0 is required, and an elaboration error is raised otherwise. NSTAGE = WIDTH/SEG.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set is presented.
- in_ready  out  1  block can accept the operand set this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_ci  in  1  carry-in (add) / borrow-in (sub).
- in_sub  in  1  0: S = A + B + ci; 1: S = A − B − ci.
- out_valid  out  1  result is presented.
- out_ready  in  1  consumer accepts the result this cycle.
- out_s  out  WIDTH  result, modulo 2^WIDTH.
- out_co  out  1  raw carry out of the MSB; for sub, 1 means no borrow.
- out_ov  out  1  signed overflow = carry-into-MSB XOR carry-out-of-MSB.

## Operation
- Entry transform:
  - sub=0: B' = B, c0 = ci.
  - sub=1: B' = ~B, c0 = ~ci. This makes A − B − ci = A + ~B + ~ci.
- Stage k (0..NSTAGE−1) register contents:
  - valid bit;
  - result segments 0..k;
  - carry out of segment k;
  - the unprocessed upper segments of A and B'.
- Stage k adds segment k with the carry from stage k−1 (stage 0 uses c0). The last stage also records the carry into bit WIDTH−1 for out_ov.
- Outputs are driven directly from the last stage register; there is no combinational path from in_* to out_*.
- Flow control is per stage, with bubble collapse:
  - stage k advances when its successor is empty or advancing;
  - the last stage advances when out_ready=1 or out_valid=0.
- in_ready = stage 0 empty OR stage 0 advancing. The only combinational dependency is on out_ready through the ready chain.
- Order is strictly preserved. No transaction is lost or duplicated.
- Capacity is NSTAGE transactions.
- NSTAGE=1 degenerates to a single registered full-width add.

## Timing
- Reset (rst=1 at an edge) clears:
  - all stage valid bits, so out_valid=0;
  - out_s=0, out_co=0, out_ov=0, and all data registers.
  - in_ready=1 in the cycle after reset.
  - Reset mid-operation discards every in-flight transaction; nothing is emitted afterwards.
- Accept: handshake at edge t (in_valid & in_ready).
- Latency: with no stall, the result is valid in the cycle after edge t+NSTAGE−1, i.e. NSTAGE cycles after acceptance.
- Throughput: 1 transaction/cycle when out_ready stays high.
- Stall:
  - while out_valid=1 and out_ready=0, out_s, out_co and out_ov are held stable;
  - upstream stages keep filling bubbles until all NSTAGE are full, then in_ready=0.
- Simultaneous accept and emit when full: if the last stage is full and out_ready=1, in_ready=1 in the same cycle, so the pipeline stays full with no bubble.
- Inputs are ignored when in_valid=0 or in_ready=0. in_* need not be held after the accepting edge.

## Test plan
- Reset: hold rst for 2 cycles with in_valid=1 → out_valid=0, out_s=0, out_co=0, out_ov=0; in_ready=1 after release; nothing emitted.
- Full carry ripple (WIDTH=32, SEG=8): A=0xFFFF_FFFF, B=0x1, ci=0, sub=0, out_ready=1 → exactly 4 cycles later S=0x0000_0000, co=1, ov=0.
- Subtract, three cases:
  - A=5, B=7, sub=1, ci=0 → S=0xFFFF_FFFE, co=0, ov=0.
  - A=0x8000_0000, B=1, sub=1 → S=0x7FFF_FFFF, co=1, ov=1.
  - A=0x7FFF_FFFF, B=1, sub=0 → S=0x8000_0000, ov=1.
- Streaming and backpressure:
  - stream 10 sequential operand sets with out_ready=0 for 6 cycles → exactly 4 accepted, then in_ready=0, out_s stable;
  - release out_ready → all 10 results emitted in order, one per cycle, none lost or duplicated.
- Reset mid-flight: 3 transactions in flight, rst pulsed 1 cycle → out_valid=0 the next cycle and no stale result ever appears.
- Parameter sweep with ~10k random transactions each, plus random in_valid/out_ready toggling, checked against a scoreboard model:
  - (WIDTH=8, SEG=8): latency 1;
  - (WIDTH=64, SEG=16);
  - (WIDTH=12, SEG=4).

Source files
------------

// File: rtl/add_pipe.sv
// add_pipe: pipelined two's-complement adder/subtractor with valid/ready on
// both sides. A WIDTH-bit add is cut into SEG-bit segments and stage k
// resolves segment k. This removes the full-width carry chain while still
// delivering one result per cycle. Each stage can fill a bubble on its own,
// so a stalled consumer lets upstream stages pack up until all NSTAGE
// slots hold a transaction.
module add_pipe #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_s,
  output logic             out_co,
  output logic             out_ov
);

  localparam int NSTAGE = WIDTH / SEG;
  localparam int LAST   = NSTAGE - 1;

  generate
    if (WIDTH < 1 || SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_param
      $error("add_pipe: WIDTH must be a positive multiple of SEG");
    end
  endgenerate

  // Per-stage registers. a_q/b_q keep the full operand, but a stage only
  // reads the segments that are still unprocessed. b_q holds B after the
  // subtract inversion.
  logic [NSTAGE-1:0] valid_q;
  logic [WIDTH-1:0]  a_q [NSTAGE];
  logic [WIDTH-1:0]  b_q [NSTAGE];
  logic [WIDTH-1:0]  s_q [NSTAGE];
  logic [NSTAGE-1:0] c_q;
  logic              ov_q;

  // Stage inputs: entry operands for stage 0, predecessor registers for
  // every later stage.
  logic [NSTAGE-1:0] up_valid;
  logic [WIDTH-1:0]  up_a [NSTAGE];
  logic [WIDTH-1:0]  up_b [NSTAGE];
  logic [WIDTH-1:0]  up_s [NSTAGE];
  logic [NSTAGE-1:0] up_c;

  logic [SEG:0]      seg_sum [NSTAGE];
  logic [WIDTH-1:0]  s_d [NSTAGE];
  logic [NSTAGE-1:0] c_d;
  logic              ov_d;
  logic [NSTAGE-1:0] ready_w;

  // Stage k may load when any stage from k to the output is empty, or when
  // the consumer is taking the last stage. The chain is built with an
  // accumulator so that it never reads back its own output.
  always_comb begin
    logic room;
    room    = out_ready;
    ready_w = '0;
    for (int k = LAST; k >= 0; k--) begin
      room       = room || !valid_q[k];
      ready_w[k] = room;
    end
  end

  // Datapath: route the stage inputs and add one segment per stage.
  always_comb begin
    up_valid[0] = in_valid;
    up_a[0]     = in_a;
    up_b[0]     = in_sub ? ~in_b : in_b;
    up_c[0]     = in_ci ^ in_sub;
    up_s[0]     = '0;
    for (int k = 1; k < NSTAGE; k++) begin
      up_valid[k] = valid_q[k-1];
      up_a[k]     = a_q[k-1];
      up_b[k]     = b_q[k-1];
      up_c[k]     = c_q[k-1];
      up_s[k]     = s_q[k-1];
    end
    for (int k = 0; k < NSTAGE; k++) begin
      seg_sum[k] = {1'b0, up_a[k][k*SEG +: SEG]}
                 + {1'b0, up_b[k][k*SEG +: SEG]}
                 + {{SEG{1'b0}}, up_c[k]};
      s_d[k]     = up_s[k];
      s_d[k][k*SEG +: SEG] = seg_sum[k][SEG-1:0];
      c_d[k]     = seg_sum[k][SEG];
    end
    // The carry into the MSB is a ^ b ^ sum at that bit. Overflow is that
    // carry XOR the carry out of the MSB.
    ov_d = up_a[LAST][WIDTH-1] ^ up_b[LAST][WIDTH-1] ^ s_d[LAST][WIDTH-1] ^ c_d[LAST];
  end

  // Stage registers: a ready stage takes its predecessor, or becomes a
  // bubble. Data only moves with a valid transaction, so a stalled output
  // holds its value.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      c_q     <= '0;
      ov_q    <= 1'b0;
      for (int k = 0; k < NSTAGE; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSTAGE; k++) begin
        if (ready_w[k]) begin
          valid_q[k] <= up_valid[k];
          if (up_valid[k]) begin
            a_q[k] <= up_a[k];
            b_q[k] <= up_b[k];
            s_q[k] <= s_d[k];
            c_q[k] <= c_d[k];
          end
        end
      end
      if (ready_w[LAST] && up_valid[LAST]) begin
        ov_q <= ov_d;
      end
    end
  end

  assign in_ready  = ready_w[0];
  assign out_valid = valid_q[LAST];
  assign out_s     = s_q[LAST];
  assign out_co    = c_q[LAST];
  assign out_ov    = ov_q;

endmodule

// File: tb/tb_add_pipe.sv
// Testbench for add_pipe. Four instances cover (32,8), (8,8), (64,16) and
// (12,4). Directed scenarios drive instance 0. A concurrent randomized sweep
// drives all four and checks them against an arithmetic reference model.
module tb_add_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [3:0] iv, ici, isub, ordy;
  wire  [3:0] irdy, ovld, oco, oov;

  logic [31:0] a0, b0;
  logic [7:0]  a1, b1;
  logic [63:0] a2, b2;
  logic [11:0] a3, b3;
  wire  [31:0] s0;
  wire  [7:0]  s1;
  wire  [63:0] s2;
  wire  [11:0] s3;

  int checks = 0;
  int passed = 0;

  logic [65:0] q0[$];
  logic [65:0] q1[$];
  logic [65:0] q2[$];
  logic [65:0] q3[$];

  add_pipe #(.WIDTH(32), .SEG(8)) u_w32 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]), .in_a(a0), .in_b(b0),
    .in_ci(ici[0]), .in_sub(isub[0]), .out_valid(ovld[0]), .out_ready(ordy[0]),
    .out_s(s0), .out_co(oco[0]), .out_ov(oov[0]));
  add_pipe #(.WIDTH(8), .SEG(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]), .in_a(a1), .in_b(b1),
    .in_ci(ici[1]), .in_sub(isub[1]), .out_valid(ovld[1]), .out_ready(ordy[1]),
    .out_s(s1), .out_co(oco[1]), .out_ov(oov[1]));
  add_pipe #(.WIDTH(64), .SEG(16)) u_w64 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]), .in_a(a2), .in_b(b2),
    .in_ci(ici[2]), .in_sub(isub[2]), .out_valid(ovld[2]), .out_ready(ordy[2]),
    .out_s(s2), .out_co(oco[2]), .out_ov(oov[2]));
  add_pipe #(.WIDTH(12), .SEG(4)) u_w12 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(irdy[3]), .in_a(a3), .in_b(b3),
    .in_ci(ici[3]), .in_sub(isub[3]), .out_valid(ovld[3]), .out_ready(ordy[3]),
    .out_s(s3), .out_co(oco[3]), .out_ov(oov[3]));

  function automatic int wid(int i);
    case (i)
      0:       return 32;
      1:       return 8;
      2:       return 64;
      default: return 12;
    endcase
  endfunction

  function automatic int nst(int i);
    case (i)
      0:       return 4;
      1:       return 1;
      2:       return 4;
      default: return 3;
    endcase
  endfunction

  function automatic logic [63:0] get_s(int i);
    case (i)
      0:       return {32'b0, s0};
      1:       return {56'b0, s1};
      2:       return s2;
      default: return {52'b0, s3};
    endcase
  endfunction

  // Reference: exact signed/unsigned arithmetic, with overflow taken from
  // range and carry/borrow taken from unsigned magnitude.
  function automatic logic [65:0] model(int w, logic [63:0] a, logic [63:0] b,
                                        logic ci, logic sub);
    logic        [66:0] mask, ua, ub, uc, lim;
    logic signed [66:0] sa, sb, res;
    logic co, ov;
    mask = (67'(1) << w) - 67'(1);
    ua   = {3'b0, a} & mask;
    ub   = {3'b0, b} & mask;
    uc   = {66'b0, ci};
    sa   = a[w-1] ? $signed(ua | ~mask) : $signed(ua);
    sb   = b[w-1] ? $signed(ub | ~mask) : $signed(ub);
    lim  = 67'(1) << (w - 1);
    if (sub) begin
      res = sa - sb - $signed(uc);
      co  = (ua >= ub + uc);
    end else begin
      res = sa + sb + $signed(uc);
      co  = ((ua + ub + uc) > mask);
    end
    ov = (res >= $signed(lim)) || (res < -$signed(lim));
    return {ov, co, res[63:0] & mask[63:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(int i, logic [63:0] a, logic [63:0] b, logic ci, logic sub, logic v);
    iv[i]   = v;
    ici[i]  = ci;
    isub[i] = sub;
    case (i)
      0:       begin a0 = a[31:0]; b0 = b[31:0]; end
      1:       begin a1 = a[7:0];  b1 = b[7:0];  end
      2:       begin a2 = a;       b2 = b;       end
      default: begin a3 = a[11:0]; b3 = b[11:0]; end
    endcase
  endtask

  task automatic idle_all();
    for (int i = 0; i < 4; i++) set_in(i, 64'h0, 64'h0, 1'b0, 1'b0, 1'b0);
    ordy = 4'hF;
  endtask

  task automatic q_push(int i, logic [65:0] v);
    case (i)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      2:       q2.push_back(v);
      default: q3.push_back(v);
    endcase
  endtask

  task automatic q_pop(int i, output logic [65:0] v, output logic ok);
    ok = 1'b1;
    v  = '0;
    case (i)
      0:       if (q0.size() > 0) v = q0.pop_front(); else ok = 1'b0;
      1:       if (q1.size() > 0) v = q1.pop_front(); else ok = 1'b0;
      2:       if (q2.size() > 0) v = q2.pop_front(); else ok = 1'b0;
      default: if (q3.size() > 0) v = q3.pop_front(); else ok = 1'b0;
    endcase
  endtask

  task automatic test_reset();
    logic seen;
    idle_all();
    rst = 1'b1;
    set_in(0, 64'h1234_5678, 64'h9, 1'b1, 1'b0, 1'b1);
    iv = 4'hF;
    tick();
    tick();
    #3;
    checks++; if (ovld !== 4'h0) $display("FAIL reset_out_valid: got %b want 0000", ovld); else passed++;
    checks++; if (s0 !== 32'h0) $display("FAIL reset_out_s: got %h want 0", s0); else passed++;
    checks++; if (oco[0] !== 1'b0) $display("FAIL reset_out_co: got %b want 0", oco[0]); else passed++;
    checks++; if (oov[0] !== 1'b0) $display("FAIL reset_out_ov: got %b want 0", oov[0]); else passed++;
    rst = 1'b0;
    iv  = 4'h0;
    #2;
    checks++; if (irdy !== 4'hF) $display("FAIL reset_in_ready: got %b want 1111", irdy); else passed++;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      #3;
      seen = seen | (|ovld);
    end
    tick();
    checks++; if (seen !== 1'b0) $display("FAIL reset_no_emit: got %b want 0", seen); else passed++;
  endtask

  task automatic test_carry_ripple();
    int n;
    idle_all();
    set_in(0, 64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, 1'b1);
    #3;
    checks++; if (irdy[0] !== 1'b1) $display("FAIL carry_accept: got %b want 1", irdy[0]); else passed++;
    tick();
    iv[0] = 1'b0;
    n = 1;
    #3;
    while (!ovld[0] && n < 20) begin tick(); n++; #3; end
    checks++; if (n != 4) $display("FAIL carry_latency: got %0d want 4", n); else passed++;
    checks++; if (s0 !== 32'h0) $display("FAIL carry_s: got %h want 00000000", s0); else passed++;
    checks++; if (oco[0] !== 1'b1) $display("FAIL carry_co: got %b want 1", oco[0]); else passed++;
    checks++; if (oov[0] !== 1'b0) $display("FAIL carry_ov: got %b want 0", oov[0]); else passed++;
    tick();
  endtask

  task automatic test_sub_overflow();
    logic [31:0] ta [3] = '{32'd5, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] tb [3] = '{32'd7, 32'd1, 32'd1};
    logic        tsb[3] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] es [3] = '{32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h8000_0000};
    logic        eco[3] = '{1'b0, 1'b1, 1'b0};
    logic        eov[3] = '{1'b0, 1'b1, 1'b1};
    int n;
    for (int t = 0; t < 3; t++) begin
      idle_all();
      set_in(0, {32'b0, ta[t]}, {32'b0, tb[t]}, 1'b0, tsb[t], 1'b1);
      tick();
      iv[0] = 1'b0;
      n = 1;
      #3;
      while (!ovld[0] && n < 20) begin tick(); n++; #3; end
      checks++; if (s0 !== es[t]) $display("FAIL arith_s[%0d]: got %h want %h", t, s0, es[t]); else passed++;
      checks++; if (oco[0] !== eco[t]) $display("FAIL arith_co[%0d]: got %b want %b", t, oco[0], eco[t]); else passed++;
      checks++; if (oov[0] !== eov[t]) $display("FAIL arith_ov[%0d]: got %b want %b", t, oov[0], eov[t]); else passed++;
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_q[$];
    logic [31:0] a, b, e;
    int nsent, nemit, first, last;
    idle_all();
    ordy[0] = 1'b0;
    nsent = 0;
    for (int c = 0; c < 6; c++) begin
      a = 32'(nsent) * 32'h1111_1111;
      b = 32'(nsent) + 32'd3;
      set_in(0, {32'b0, a}, {32'b0, b}, 1'b0, 1'b0, 1'b1);
      #3;
      if (irdy[0]) begin exp_q.push_back(a + b); nsent++; end
      if (c >= 4) begin
        checks++;
        if (ovld[0] !== 1'b1 || s0 !== exp_q[0])
          $display("FAIL stall_hold[%0d]: got valid=%b s=%h want valid=1 s=%h", c, ovld[0], s0, exp_q[0]);
        else passed++;
      end
      tick();
    end
    #3;
    checks++; if (nsent != 4) $display("FAIL stall_accepted: got %0d want 4", nsent); else passed++;
    checks++; if (irdy[0] !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", irdy[0]); else passed++;
    tick();
    ordy[0] = 1'b1;
    nemit = 0; first = -1; last = -1;
    for (int c = 0; c < 40 && (nemit < 10); c++) begin
      if (nsent < 10) begin
        a = 32'(nsent) * 32'h1111_1111;
        b = 32'(nsent) + 32'd3;
        set_in(0, {32'b0, a}, {32'b0, b}, 1'b0, 1'b0, 1'b1);
      end else begin
        iv[0] = 1'b0;
      end
      #3;
      if (iv[0] && irdy[0]) begin exp_q.push_back(a + b); nsent++; end
      if (ovld[0]) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        checks++; if (s0 !== e) $display("FAIL stream_s[%0d]: got %h want %h", nemit, s0, e); else passed++;
        if (first < 0) first = c;
        last = c;
        nemit++;
      end
      tick();
    end
    iv[0] = 1'b0;
    checks++; if (nemit != 10) $display("FAIL stream_count: got %0d want 10", nemit); else passed++;
    checks++; if (last - first + 1 != 10) $display("FAIL stream_gapless: got span %0d want 10", last - first + 1); else passed++;
  endtask

  task automatic test_reset_midflight();
    logic seen;
    idle_all();
    for (int k = 0; k < 3; k++) begin
      set_in(0, 64'(k + 1), 64'(k + 2), 1'b0, 1'b0, 1'b1);
      tick();
    end
    iv[0] = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #3;
    checks++; if (ovld[0] !== 1'b0) $display("FAIL midrst_valid: got %b want 0", ovld[0]); else passed++;
    checks++; if (irdy[0] !== 1'b1) $display("FAIL midrst_ready: got %b want 1", irdy[0]); else passed++;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      #3;
      seen = seen | ovld[0];
    end
    tick();
    checks++; if (seen !== 1'b0) $display("FAIL midrst_stale: got %b want 0", seen); else passed++;
  endtask

  task automatic test_latency();
    int order [3] = '{1, 3, 2};
    int i, n;
    logic [63:0] a, b;
    logic [65:0] e;
    for (int t = 0; t < 3; t++) begin
      i = order[t];
      idle_all();
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      set_in(i, a, b, 1'b1, 1'b0, 1'b1);
      e = model(wid(i), a, b, 1'b1, 1'b0);
      tick();
      iv[i] = 1'b0;
      n = 1;
      #3;
      while (!ovld[i] && n < 20) begin tick(); n++; #3; end
      checks++; if (n != nst(i)) $display("FAIL latency_w%0d: got %0d want %0d", wid(i), n, nst(i)); else passed++;
      checks++;
      if ({oov[i], oco[i], get_s(i)} !== e)
        $display("FAIL latency_result_w%0d: got %h want %h", wid(i), {oov[i], oco[i], get_s(i)}, e);
      else passed++;
      tick();
    end
  endtask

  task automatic test_sweep();
    localparam int NCYC = 16000;
    logic [63:0] sa [4];
    logic [63:0] sb [4];
    logic [3:0]  sci, ssb;
    logic [3:0]  prev_stall;
    logic [65:0] prev_out [4];
    logic [65:0] cur, e;
    logic        ok;
    int          nacc [4];
    idle_all();
    prev_stall = '0;
    for (int i = 0; i < 4; i++) begin prev_out[i] = '0; nacc[i] = 0; end
    for (int c = 0; c < NCYC + 60; c++) begin
      for (int i = 0; i < 4; i++) begin
        sa[i] = {$urandom, $urandom};
        sb[i] = {$urandom, $urandom};
        case ($urandom_range(0, 7))
          0: sa[i] = '1;
          1: sb[i] = '1;
          2: sa[i] = 64'(1) << (wid(i) - 1);
          3: begin sa[i] = (64'(1) << (wid(i) - 1)) - 64'(1); sb[i] = 64'(1); end
          default: ;
        endcase
        sci[i] = 1'($urandom_range(0, 1));
        ssb[i] = 1'($urandom_range(0, 1));
        if (c < NCYC) begin
          set_in(i, sa[i], sb[i], sci[i], ssb[i], $urandom_range(0, 3) != 0);
          ordy[i] = ($urandom_range(0, 3) != 0);
        end else begin
          set_in(i, sa[i], sb[i], sci[i], ssb[i], 1'b0);
          ordy[i] = 1'b1;
        end
      end
      #3;
      for (int i = 0; i < 4; i++) begin
        cur = {oov[i], oco[i], get_s(i)};
        if (prev_stall[i]) begin
          checks++;
          if (!ovld[i] || cur !== prev_out[i])
            $display("FAIL sweep_hold_w%0d: got v=%b %h want v=1 %h", wid(i), ovld[i], cur, prev_out[i]);
          else passed++;
        end
        if (iv[i] && irdy[i]) begin
          q_push(i, model(wid(i), sa[i], sb[i], sci[i], ssb[i]));
          nacc[i]++;
        end
        if (ovld[i] && ordy[i]) begin
          q_pop(i, e, ok);
          checks++;
          if (!ok) $display("FAIL sweep_spurious_w%0d: got %h want nothing", wid(i), cur);
          else if (cur !== e) $display("FAIL sweep_result_w%0d: got %h want %h", wid(i), cur, e);
          else passed++;
        end
        prev_stall[i] = ovld[i] && !ordy[i];
        prev_out[i]   = cur;
      end
      tick();
    end
    checks++; if (q0.size() != 0) $display("FAIL sweep_lost_w32: got %0d left want 0", q0.size()); else passed++;
    checks++; if (q1.size() != 0) $display("FAIL sweep_lost_w8: got %0d left want 0", q1.size()); else passed++;
    checks++; if (q2.size() != 0) $display("FAIL sweep_lost_w64: got %0d left want 0", q2.size()); else passed++;
    checks++; if (q3.size() != 0) $display("FAIL sweep_lost_w12: got %0d left want 0", q3.size()); else passed++;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (nacc[i] < 1000) $display("FAIL sweep_traffic_w%0d: got %0d accepted want >=1000", wid(i), nacc[i]);
      else passed++;
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    test_reset();
    test_carry_ripple();
    test_sub_overflow();
    test_backpressure();
    test_reset_midflight();
    test_latency();
    test_sweep();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
